// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM voltage-loop controller: datapath widths,
// FSM state encoding, default loop gains/limits and the integrator saturator.
package pwm_ctrl_pkg;

  localparam int DUTY_W = 32'sd10;
  localparam int ERR_W  = 32'sd11;
  localparam int INT_W  = 32'sd22;
  localparam int PROD_W = 32'sd20;
  localparam int SUM_W  = 32'sd24;

  typedef logic [2:0] pi_state_t;

  localparam pi_state_t ST_IDLE = 3'd0;
  localparam pi_state_t ST_ERR  = 3'd1;
  localparam pi_state_t ST_MUL  = 3'd2;
  localparam pi_state_t ST_SUM  = 3'd3;
  localparam pi_state_t ST_OUT  = 3'd4;

  localparam logic [7:0]        KP_DEF       = 8'd16;
  localparam int                KP_SHIFT_DEF = 32'sd4;
  localparam logic [7:0]        KI_DEF       = 8'd2;
  localparam int                KI_SHIFT_DEF = 32'sd6;
  localparam logic [DUTY_W-1:0] MARGIN_DEF   = 10'd4;
  localparam logic [DUTY_W-1:0] OV_LIMIT_DEF = 10'd900;
  localparam int                OV_COUNT_DEF = 32'sd3;

  localparam logic signed [INT_W-1:0] INT_MAX = 22'sh1FFFFF;
  localparam logic signed [INT_W-1:0] INT_MIN = 22'sh200001;

  // Symmetric saturation of the one-bit-wider integrator sum back to INT_W bits.
  function automatic logic signed [INT_W-1:0] sat_integ(input logic signed [INT_W:0] x);
    logic signed [INT_W:0] hi_s;
    logic signed [INT_W:0] lo_s;
    hi_s = {1'b0, INT_MAX};
    lo_s = {1'b1, INT_MIN};
    if (x > hi_s) begin
      return INT_MAX;
    end else if (x < lo_s) begin
      return INT_MIN;
    end else begin
      return x[INT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/duty_clamp.sv
// Clamps the raw signed controller output into [0, maxcount - MARGIN] and
// reports which bound (if any) was hit.
module duty_clamp
  import pwm_ctrl_pkg::*;
#(
  parameter logic [DUTY_W-1:0] MARGIN = MARGIN_DEF
) (
  input  logic signed [SUM_W-1:0]  u,
  input  logic        [DUTY_W-1:0] maxcount,
  output logic        [DUTY_W-1:0] duty_c,
  output logic                     sat_hi,
  output logic                     sat_lo
);

  logic [DUTY_W-1:0]       upper_s;
  logic signed [SUM_W-1:0] upper_ext_s;

  assign upper_s     = (maxcount < MARGIN) ? 10'd0 : (maxcount - MARGIN);
  assign upper_ext_s = {{(SUM_W-DUTY_W){1'b0}}, upper_s};

  // Upper bound checked first so a zero-width window reports sat_hi.
  always_comb begin
    duty_c = 10'd0;
    sat_hi = 1'b0;
    sat_lo = 1'b0;
    if (u > upper_ext_s) begin
      duty_c = upper_s;
      sat_hi = 1'b1;
    end else if (u < 24'sd0) begin
      duty_c = 10'd0;
      sat_lo = 1'b1;
    end else begin
      duty_c = u[DUTY_W-1:0];
    end
  end

endmodule

// File: rtl/pi_duty_controller.sv
// Digital PI voltage loop: a four-step sequencer (error, multiply, sum, output)
// that turns each ADC sample into a clamped duty count, with anti-windup and OV trip.
module pi_duty_controller
  import pwm_ctrl_pkg::*;
#(
  parameter logic [7:0]        KP       = KP_DEF,
  parameter int                KP_SHIFT = KP_SHIFT_DEF,
  parameter logic [7:0]        KI       = KI_DEF,
  parameter int                KI_SHIFT = KI_SHIFT_DEF,
  parameter logic [DUTY_W-1:0] MARGIN   = MARGIN_DEF,
  parameter logic [DUTY_W-1:0] OV_LIMIT = OV_LIMIT_DEF,
  parameter int                OV_COUNT = OV_COUNT_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              EN,
  input  logic              sample_valid,
  input  logic [DUTY_W-1:0] adc_sample,
  input  logic [DUTY_W-1:0] vref,
  input  logic [DUTY_W-1:0] duty_ff,
  input  logic [DUTY_W-1:0] maxcount,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              sat_hi,
  output logic              sat_lo,
  output logic              busy,
  output logic              overrun,
  output logic              fault
);

  pi_state_t                state_r;
  pi_state_t                state_nxt_s;

  logic [DUTY_W-1:0]        adc_r;
  logic [DUTY_W-1:0]        vref_r;
  logic [DUTY_W-1:0]        ff_r;
  logic [DUTY_W-1:0]        max_r;
  logic signed [ERR_W-1:0]  e_r;
  logic signed [PROD_W-1:0] p_r;
  logic signed [PROD_W-1:0] inc_r;
  logic signed [INT_W-1:0]  integ_r;
  logic [7:0]               ov_cnt_r;
  logic                     trip_r;
  logic [DUTY_W-1:0]        duty_hold_r;
  logic                     sat_hi_hold_r;
  logic                     sat_lo_hold_r;

  logic [DUTY_W-1:0]        duty_r;
  logic                     duty_valid_r;
  logic                     sat_hi_r;
  logic                     sat_lo_r;
  logic                     busy_r;
  logic                     ovr_pend_r;
  logic                     overrun_r;
  logic                     fault_r;

  logic                     accept_s;
  logic                     drop_s;
  logic signed [ERR_W-1:0]  err_s;
  logic signed [PROD_W-1:0] e_ext_s;
  logic signed [PROD_W-1:0] kp_ext_s;
  logic signed [PROD_W-1:0] ki_ext_s;
  logic signed [PROD_W-1:0] prod_p_s;
  logic signed [PROD_W-1:0] p_s;
  logic signed [PROD_W-1:0] inc_s;
  logic signed [INT_W:0]    integ_sum_s;
  logic signed [INT_W-1:0]  integ_new_s;
  logic signed [INT_W-1:0]  integ_sh_s;
  logic signed [SUM_W-1:0]  u_s;
  logic [DUTY_W-1:0]        clamp_duty_s;
  logic                     clamp_hi_s;
  logic                     clamp_lo_s;
  logic                     commit_s;
  logic [7:0]               ov_inc_s;
  logic                     ov_hit_s;
  logic                     trip_s;

  // A faulted controller neither accepts nor flags samples.
  assign accept_s = (state_r == ST_IDLE) && sample_valid && EN && !fault_r;
  assign drop_s   = (state_r != ST_IDLE) && sample_valid && EN && !fault_r;

  assign err_s    = $signed({1'b0, vref_r}) - $signed({1'b0, adc_r});
  assign e_ext_s  = {{(PROD_W-ERR_W){e_r[ERR_W-1]}}, e_r};
  assign kp_ext_s = {{(PROD_W-8){1'b0}}, KP};
  assign ki_ext_s = {{(PROD_W-8){1'b0}}, KI};
  assign prod_p_s = e_ext_s * kp_ext_s;
  assign p_s      = prod_p_s >>> KP_SHIFT;
  assign inc_s    = e_ext_s * ki_ext_s;

  assign integ_sum_s = {integ_r[INT_W-1], integ_r}
                     + {{(INT_W+1-PROD_W){inc_r[PROD_W-1]}}, inc_r};
  assign integ_new_s = sat_integ(integ_sum_s);
  assign integ_sh_s  = integ_new_s >>> KI_SHIFT;

  assign u_s = {{(SUM_W-DUTY_W){1'b0}}, ff_r}
             + {{(SUM_W-PROD_W){p_r[PROD_W-1]}}, p_r}
             + {{(SUM_W-INT_W){integ_sh_s[INT_W-1]}}, integ_sh_s};

  duty_clamp #(
    .MARGIN (MARGIN)
  ) u_clamp (
    .u        (u_s),
    .maxcount (max_r),
    .duty_c   (clamp_duty_s),
    .sat_hi   (clamp_hi_s),
    .sat_lo   (clamp_lo_s)
  );

  // Anti-windup: freeze the integrator while it would push further into a clamp.
  assign commit_s = !((clamp_hi_s && (e_r > 11'sd0)) || (clamp_lo_s && (e_r < 11'sd0)));

  assign ov_inc_s = (ov_cnt_r == 8'hFF) ? 8'hFF : (ov_cnt_r + 8'd1);
  assign ov_hit_s = (adc_sample >= OV_LIMIT);
  assign trip_s   = ov_hit_s && ({24'd0, ov_inc_s} >= OV_COUNT);

  // Sequencer next-state: every non-idle step takes exactly one cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ERR:  state_nxt_s = ST_MUL;
      ST_MUL:  state_nxt_s = ST_SUM;
      ST_SUM:  state_nxt_s = ST_OUT;
      ST_OUT:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Pipeline, loop state and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      adc_r         <= 10'd0;
      vref_r        <= 10'd0;
      ff_r          <= 10'd0;
      max_r         <= 10'd0;
      e_r           <= 11'sd0;
      p_r           <= 20'sd0;
      inc_r         <= 20'sd0;
      integ_r       <= 22'sd0;
      ov_cnt_r      <= 8'd0;
      trip_r        <= 1'b0;
      duty_hold_r   <= 10'd0;
      sat_hi_hold_r <= 1'b0;
      sat_lo_hold_r <= 1'b0;
      duty_r        <= 10'd0;
      duty_valid_r  <= 1'b0;
      sat_hi_r      <= 1'b0;
      sat_lo_r      <= 1'b0;
      busy_r        <= 1'b0;
      ovr_pend_r    <= 1'b0;
      overrun_r     <= 1'b0;
      fault_r       <= 1'b0;
    end else if (!EN) begin
      state_r      <= ST_IDLE;
      integ_r      <= 22'sd0;
      ov_cnt_r     <= 8'd0;
      trip_r       <= 1'b0;
      duty_r       <= 10'd0;
      duty_valid_r <= 1'b0;
      sat_hi_r     <= 1'b0;
      sat_lo_r     <= 1'b0;
      busy_r       <= 1'b0;
      ovr_pend_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
      duty_valid_r <= 1'b0;
      ovr_pend_r   <= drop_s;
      overrun_r    <= overrun_r | ovr_pend_r;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            adc_r    <= adc_sample;
            vref_r   <= vref;
            ff_r     <= duty_ff;
            max_r    <= maxcount;
            ov_cnt_r <= ov_hit_s ? ov_inc_s : 8'd0;
            trip_r   <= trip_s;
          end
        end
        ST_ERR: e_r <= err_s;
        ST_MUL: begin
          p_r   <= p_s;
          inc_r <= inc_s;
        end
        ST_SUM: begin
          duty_hold_r   <= clamp_duty_s;
          sat_hi_hold_r <= clamp_hi_s;
          sat_lo_hold_r <= clamp_lo_s;
          if (commit_s) begin
            integ_r <= integ_new_s;
          end
        end
        ST_OUT: begin
          duty_valid_r <= 1'b1;
          if (trip_r) begin
            fault_r  <= 1'b1;
            duty_r   <= 10'd0;
            sat_hi_r <= 1'b0;
            sat_lo_r <= 1'b0;
            integ_r  <= 22'sd0;
          end else begin
            duty_r   <= duty_hold_r;
            sat_hi_r <= sat_hi_hold_r;
            sat_lo_r <= sat_lo_hold_r;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign duty       = duty_r;
  assign duty_valid = duty_valid_r;
  assign sat_hi     = sat_hi_r;
  assign sat_lo     = sat_lo_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;
  assign fault      = fault_r;

endmodule

// File: doc/pi_duty_controller.md
PI_DUTY_CONTROLLER -- requirements
Module: pi_duty_controller

Interface
REQ-001 Parameter KP, default 8'd16, proportional gain numerator (unsigned).
REQ-002 Parameter KP_SHIFT, default 4, proportional gain right-shift (gain = KP/2^KP_SHIFT).
REQ-003 Parameter KI, default 8'd2, integral gain per sample (unsigned).
REQ-004 Parameter KI_SHIFT, default 6, arithmetic right-shift applied to integrator before summing.
REQ-005 Parameter MARGIN, default 10'd4, counts kept below maxcount at upper clamp.
REQ-006 Parameter OV_LIMIT, default 10'd900, overvoltage threshold in ADC codes.
REQ-007 Parameter OV_COUNT, default 3, consecutive over-limit samples that trip the fault.
REQ-008 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 EN  in  1  controller enable; low forces idle and clears loop state.
REQ-011 sample_valid  in  1  one-cycle strobe: adc_sample is valid.
REQ-012 adc_sample  in  10  measured output voltage, unsigned code.
REQ-013 vref  in  10  voltage setpoint, unsigned code.
REQ-014 duty_ff  in  10  feed-forward nominal duty count (from the duty converter).
REQ-015 maxcount  in  10  DPWM period count for the active frequency.
REQ-016 duty  out  10  clamped duty count for the AdjustDuty/DPWM stage.
REQ-017 duty_valid  out  1  one-cycle pulse when duty updates.
REQ-018 sat_hi, sat_lo  out  1 each  last computed duty hit upper/lower clamp.
REQ-019 busy  out  1  high whenever FSM is not IDLE.
REQ-020 overrun  out  1  sticky: a sample arrived while busy.
REQ-021 fault  out  1  sticky overvoltage fault.

Function
REQ-022 FSM states IDLE, ERR, MUL, SUM, OUT; each non-IDLE state lasts exactly one cycle.
REQ-023 IDLE->ERR when sample_valid=1, EN=1, fault=0; adc_sample, vref, duty_ff, maxcount are captured at that edge (edge k).
REQ-024 ERR: e = vref - adc_sample as 11-bit signed.
REQ-025 MUL: p = (e*KP) >>> KP_SHIFT; inc = e*KI; all signed, full precision.
REQ-026 SUM: integ_new = integ + inc, saturated to ±(2^21-1) (22-bit signed); u = duty_ff + p + (integ_new >>> KI_SHIFT).
REQ-027 Clamp: upper = maxcount - MARGIN (0 if maxcount < MARGIN); u > upper -> upper, sat_hi=1; u < 0 -> 0, sat_lo=1; else both 0.
REQ-028 Anti-windup: integ is not committed when (sat_hi and e>0) or (sat_lo and e<0); otherwise integ <= integ_new.
REQ-029 OUT: duty and duty_valid update at edge k+4; duty_valid high for exactly one cycle; then return to IDLE.
REQ-030 Back-to-back: a sample may be accepted in the IDLE cycle immediately after OUT (minimum spacing 5 cycles).
REQ-031 sample_valid while busy: sample dropped, overrun set at next edge, in-flight computation unaffected.
REQ-032 OV: each accepted sample with adc_sample >= OV_LIMIT increments ov_cnt, else ov_cnt clears; reaching OV_COUNT sets fault.
REQ-033 Fault: at the tripping sample's OUT edge duty=0, duty_valid pulses, integ cleared; thereafter samples are ignored (no overrun), duty stays 0.
REQ-034 EN=0: at the next edge FSM->IDLE, integ=0, ov_cnt=0, duty=0, duty_valid=0, sat flags 0; overrun and fault hold.
REQ-035 duty holds its value between duty_valid pulses.

Reset
REQ-036 reset=1 at any edge, in any state, forces: FSM IDLE, duty=0, duty_valid=0, sat_hi=0, sat_lo=0, busy=0, overrun=0, fault=0, integ=0, ov_cnt=0.
REQ-037 reset dominates EN and sample_valid; a sample coincident with reset is discarded.

Structure
REQ-038 Shared package pwm_ctrl_pkg holds the FSM state type, DUTY_W=10, ERR_W=11, INT_W=22, and the default gain/limit constants.
REQ-039 Saturation/clamp logic (REQ-027) lives in one sub-module, duty_clamp; everything else is in pi_duty_controller.

Verification
REQ-040 maxcount=357, duty_ff=300, vref=adc=512, sample at edge k -> duty=300 and duty_valid pulse at k+4, sat flags 0.
REQ-041 Same setup, vref=522, adc=512 -> duty=310; internal integ=20.
REQ-042 duty_ff=350, maxcount=357, e=+100 -> duty=353, sat_hi=1, integ unchanged at 0; duty_ff=10, e=-100 -> duty=0, sat_lo=1, integ unchanged.
REQ-043 Three consecutive samples adc=950 -> fault=1 and duty=0 at third sample's k+4; a following sample gives no busy; reset clears fault; pattern 950,100,950 -> no fault.
REQ-044 sample_valid at k and k+2 -> one duty_valid at k+4, overrun=1 from k+3; reset at k+2 of a new sample -> no duty_valid, all outputs 0.
